// File: rtl/instr_encoder_loader_pkg.sv
// Shared op-class codes, MIPS opcodes and beat/state types for the instruction loader.
// The decoder imports the same package, so the encodings cannot diverge.
package instr_encoder_loader_pkg;

    typedef enum logic [2:0] {
        OPS_R_TYPE  = 3'd0,
        OPS_ADDI    = 3'd1,
        OPS_SLTIU   = 3'd2,
        OPS_BEQ     = 3'd3,
        OPS_LUI     = 3'd4,
        OPS_ORI     = 3'd5,
        OPS_BNE     = 3'd6,
        OPS_ILLEGAL = 3'd7
    } op_sel_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_BNE   = 6'h05;

    typedef struct packed {
        op_sel_e     op_sel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } instr_beat_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Beat-in / imem-write-out bus of the instruction loader.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic              valid_i;
    logic              ready_o;
    logic [2:0]        op_sel_i;
    logic [4:0]        rs_i, rt_i, rd_i, shamt_i;
    logic [5:0]        funct_i;
    logic [15:0]       imm_i;
    logic              last_i;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_data_o;
    logic              imem_ack_i;
    logic [CNT_W-1:0]  count_o;
    logic              done_o;
    logic              err_o;

    modport master (
        output start_i, base_addr_i, valid_i, op_sel_i, rs_i, rt_i, rd_i, shamt_i,
               funct_i, imm_i, last_i, imem_ack_i,
        input  ready_o, imem_we_o, imem_addr_o, imem_data_o, count_o, done_o, err_o
    );

    modport slave (
        input  start_i, base_addr_i, valid_i, op_sel_i, rs_i, rt_i, rd_i, shamt_i,
               funct_i, imm_i, last_i, imem_ack_i,
        output ready_o, imem_we_o, imem_addr_o, imem_data_o, count_o, done_o, err_o
    );
endinterface

// File: rtl/instr_encoder_loader_fifo.sv
// Registered FIFO for encoded words; full/empty come straight from the pointers.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty_o = (wptr == rptr);
    assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign data_o  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_i && !full_o) wptr <= wptr + 1'b1;
            if (pop_i && !empty_o) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem[wptr[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes op-class beats into MIPS words, buffers them and writes them to
// instruction memory at consecutive word addresses.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    instr_encoder_loader_if.slave bus
);
    state_t            state, state_nxt;
    instr_beat_t       beat;
    logic              last_seen, err;
    logic              fifo_full, fifo_empty, accept, illegal, push, pop;
    logic [31:0]       head;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  count;

    function automatic logic [31:0] encode(instr_beat_t b);
        logic [31:0] w;
        w = '0;
        case (b.op_sel)
            OPS_R_TYPE: w = {OPC_RTYPE, b.rs, b.rt, b.rd, b.shamt, b.funct};
            OPS_ADDI:   w = {OPC_ADDI,  b.rs, b.rt, b.imm};
            OPS_SLTIU:  w = {OPC_SLTIU, b.rs, b.rt, b.imm};
            OPS_BEQ:    w = {OPC_BEQ,   b.rs, b.rt, b.imm};
            OPS_LUI:    w = {OPC_LUI,   5'd0, b.rt, b.imm};
            OPS_ORI:    w = {OPC_ORI,   b.rs, b.rt, b.imm};
            OPS_BNE:    w = {OPC_BNE,   b.rs, b.rt, b.imm};
            default:    w = '0;
        endcase
        return w;
    endfunction

    assign beat = '{op_sel: op_sel_e'(bus.op_sel_i), rs: bus.rs_i, rt: bus.rt_i,
                    rd: bus.rd_i, shamt: bus.shamt_i, funct: bus.funct_i, imm: bus.imm_i};

    assign bus.ready_o = (state == S_RUN) && !fifo_full && !last_seen;
    assign accept      = bus.valid_i && bus.ready_o;
    assign illegal     = (beat.op_sel == OPS_ILLEGAL);
    assign push        = accept && !illegal;
    assign bus.imem_we_o   = (state == S_RUN) && !fifo_empty;
    assign pop             = bus.imem_we_o && bus.imem_ack_i;
    assign bus.imem_addr_o = addr;
    assign bus.imem_data_o = head;
    assign bus.count_o     = count;
    assign bus.done_o      = (state == S_DONE);
    assign bus.err_o       = err;

    instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (encode(beat)),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Session ends only once the final beat is in and every buffered word has drained.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start_i) state_nxt = S_RUN;
            S_RUN:   if (last_seen && fifo_empty) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_seen <= 1'b0;
            err       <= 1'b0;
            addr      <= '0;
            count     <= '0;
        end else if (state == S_IDLE && bus.start_i) begin
            last_seen <= 1'b0;
            err       <= 1'b0;
            addr      <= bus.base_addr_i & ~ADDR_W'(3);
            count     <= '0;
        end else begin
            if (accept && bus.last_i) last_seen <= 1'b1;
            if (accept && illegal)    err       <= 1'b1;
            if (pop) begin
                addr  <= addr + ADDR_W'(4);
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for the instruction loader: encodings, back-pressure, wrap, illegal ops, reset abort.
module tb_instr_encoder_loader;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    instr_encoder_loader_if #(.ADDR_W(32), .CNT_W(16)) bus ();

    instr_encoder_loader #(.DEPTH(4), .ADDR_W(32), .CNT_W(16)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int done_cnt = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int w0, d0;

    // Writes complete on edges where we & ack; inputs only change at posedge+2.
    always @(negedge clk_i) begin
        if (bus.imem_we_o && bus.imem_ack_i) begin
            wa_q.push_back(bus.imem_addr_o);
            wd_q.push_back(bus.imem_data_o);
        end
        if (bus.done_o) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic start_sess(input logic [31:0] base);
        bus.start_i     = 1'b1;
        bus.base_addr_i = base;
        tick();
        bus.start_i     = 1'b0;
    endtask

    task automatic offer(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] imm, input logic last);
        bus.op_sel_i = op; bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd;
        bus.shamt_i = sh; bus.funct_i = fn; bus.imm_i = imm; bus.last_i = last;
        bus.valid_i = 1'b1;
    endtask

    task automatic await_acc(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_i);
            ok = bus.ready_o;
            tick();
        end
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
        if (!ok) chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic beat(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic last);
        offer(op, rs, rt, rd, sh, fn, imm, last);
        await_acc("beat_timeout");
    endtask

    task automatic wait_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk_i);
            ok = bus.done_o;
        end
        tick();
        if (!ok) chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start_i = 0; bus.base_addr_i = '0; bus.valid_i = 0; bus.op_sel_i = '0;
        bus.rs_i = '0; bus.rt_i = '0; bus.rd_i = '0; bus.shamt_i = '0; bus.funct_i = '0;
        bus.imm_i = '0; bus.last_i = 0; bus.imem_ack_i = 0;

        repeat (3) @(negedge clk_i);
        chk("rst_we",    32'(bus.imem_we_o), 32'd0);
        chk("rst_ready", 32'(bus.ready_o),   32'd0);
        chk("rst_count", 32'(bus.count_o),   32'd0);
        chk("rst_done",  32'(bus.done_o),    32'd0);
        chk("rst_err",   32'(bus.err_o),     32'd0);
        chk("rst_addr",  bus.imem_addr_o,    32'd0);
        tick();
        rst_i = 1'b1;
        tick();

        // Single ADDI, ack tied high
        bus.imem_ack_i = 1'b1;
        w0 = wa_q.size(); d0 = done_cnt;
        start_sess(32'h100);
        beat(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 1'b1);
        wait_done("t1_done_timeout");
        repeat (2) tick();
        chk("t1_nwr",   32'(wa_q.size() - w0), 32'd1);
        chk("t1_addr",  wa_q[w0], 32'h0000_0100);
        chk("t1_data",  wd_q[w0], 32'h2022_0005);
        chk("t1_count", 32'(bus.count_o), 32'd1);
        chk("t1_done1", 32'(done_cnt - d0), 32'd1);

        // R_TYPE, LUI (rs forced 0), BNE
        w0 = wa_q.size();
        start_sess(32'h200);
        beat(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 1'b0);
        beat(3'd4, 5'd7, 5'd4, 5'd0, 5'd0, 6'h00, 16'h1234, 1'b0);
        beat(3'd6, 5'd1, 5'd0, 5'd0, 5'd0, 6'h00, 16'hFFFF, 1'b1);
        wait_done("t2_done_timeout");
        chk("t2_nwr",    32'(wa_q.size() - w0), 32'd3);
        chk("t2_rtype",  wd_q[w0],     32'h0022_1820);
        chk("t2_lui",    wd_q[w0 + 1], 32'h3C04_1234);
        chk("t2_bne",    wd_q[w0 + 2], 32'h1420_FFFF);
        chk("t2_addr2",  wa_q[w0 + 2], 32'h0000_0208);
        chk("t2_count",  32'(bus.count_o), 32'd3);

        // Back-pressure: ack low, FIFO fills at 4, fifth beat stalls
        bus.imem_ack_i = 1'b0;
        w0 = wa_q.size(); d0 = done_cnt;
        start_sess(32'h100);
        for (int k = 0; k < 4; k++) beat(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'(k), 1'b0);
        offer(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'd4, 1'b1);
        @(negedge clk_i);
        chk("t3_ready0", 32'(bus.ready_o), 32'd0);
        chk("t3_we",     32'(bus.imem_we_o), 32'd1);
        chk("t3_addr",   bus.imem_addr_o, 32'h0000_0100);
        chk("t3_data",   bus.imem_data_o, 32'h2022_0000);
        repeat (4) tick();
        @(negedge clk_i);
        chk("t3_ready0b", 32'(bus.ready_o), 32'd0);
        chk("t3_we_hold", 32'(bus.imem_we_o), 32'd1);
        chk("t3_addr_hold", bus.imem_addr_o, 32'h0000_0100);
        chk("t3_data_hold", bus.imem_data_o, 32'h2022_0000);
        chk("t3_nwr0",    32'(wa_q.size() - w0), 32'd0);
        tick();
        bus.imem_ack_i = 1'b1;
        await_acc("t3_acc5_timeout");
        wait_done("t3_done_timeout");
        chk("t3_nwr", 32'(wa_q.size() - w0), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_addr%0d", k), wa_q[w0 + k], 32'h100 + 32'(4 * k));
            chk($sformatf("t3_data%0d", k), wd_q[w0 + k], 32'h2022_0000 + 32'(k));
        end
        chk("t3_count", 32'(bus.count_o), 32'd5);
        chk("t3_done1", 32'(done_cnt - d0), 32'd1);

        // Illegal op mid-stream
        w0 = wa_q.size();
        start_sess(32'h300);
        beat(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'd1, 1'b0);
        beat(3'd7, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'd9, 1'b0);
        chk("t4_err_set", 32'(bus.err_o), 32'd1);
        beat(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'd2, 1'b1);
        wait_done("t4_done_timeout");
        chk("t4_nwr",    32'(wa_q.size() - w0), 32'd2);
        chk("t4_addr1",  wa_q[w0 + 1], 32'h0000_0304);
        chk("t4_data1",  wd_q[w0 + 1], 32'h2022_0002);
        chk("t4_err_hold", 32'(bus.err_o), 32'd1);

        // Illegal op carrying last still finishes the session
        w0 = wa_q.size(); d0 = done_cnt;
        start_sess(32'h400);
        chk("t4b_err_clr", 32'(bus.err_o), 32'd0);
        beat(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'd3, 1'b0);
        beat(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 1'b1);
        wait_done("t4b_done_timeout");
        tick();
        chk("t4b_nwr",   32'(wa_q.size() - w0), 32'd1);
        chk("t4b_count", 32'(bus.count_o), 32'd1);
        chk("t4b_err",   32'(bus.err_o), 32'd1);
        chk("t4b_done1", 32'(done_cnt - d0), 32'd1);

        // Address wrap
        w0 = wa_q.size();
        start_sess(32'hFFFF_FFFC);
        beat(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0010, 1'b0);
        beat(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0011, 1'b1);
        wait_done("t5_done_timeout");
        chk("t5_addr0", wa_q[w0],     32'hFFFF_FFFC);
        chk("t5_addr1", wa_q[w0 + 1], 32'h0000_0000);
        chk("t5_count", 32'(bus.count_o), 32'd2);

        // Reset while words are buffered and a write is pending
        bus.imem_ack_i = 1'b0;
        start_sess(32'h500);
        for (int k = 0; k < 3; k++) beat(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0050 + 16'(k), 1'b0);
        @(negedge clk_i);
        chk("t6_we_pre", 32'(bus.imem_we_o), 32'd1);
        tick();
        rst_i = 1'b0;
        #1;
        chk("t6_we_rst",    32'(bus.imem_we_o), 32'd0);
        chk("t6_ready_rst", 32'(bus.ready_o), 32'd0);
        chk("t6_count_rst", 32'(bus.count_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        bus.imem_ack_i = 1'b1;
        w0 = wa_q.size();
        start_sess(32'h600);
        chk("t6_count0", 32'(bus.count_o), 32'd0);
        beat(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0066, 1'b1);
        wait_done("t6_done_timeout");
        chk("t6_nwr",   32'(wa_q.size() - w0), 32'd1);
        chk("t6_addr",  wa_q[w0], 32'h0000_0600);
        chk("t6_data",  wd_q[w0], 32'h2022_0066);
        chk("t6_count", 32'(bus.count_o), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
